// File: rtl/cmd_parser.sv
// SUMP host command parser: rx bytes -> opcode / config_data / execute.
// Optional inter-byte timeout for long commands: `define CMD_TIMEOUT_EN.
module cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TIMEOUT_WIDTH  = 17
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        parserIdle,
  output logic        cmdAbort
);

  typedef enum logic {S_IDLE, S_DATA} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  sh_op_q, sh_op_d;
  logic [31:0] sh_data_q, sh_data_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] cfg_q, cfg_d;
  logic        exec_q, exec_d;
  logic        abort_q, abort_d;
  logic        expire;

  if (TIMEOUT_CYCLES < 2 ||
      longint'(TIMEOUT_CYCLES) > (longint'(1) << TIMEOUT_WIDTH))
  begin : g_cfg_chk
    $error("cmd_parser: TIMEOUT_WIDTH cannot hold TIMEOUT_CYCLES-1");
  end

`ifdef CMD_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;

  always_comb begin
    expire = (state_q == S_DATA) && !rxValid &&
             (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    tmo_d  = tmo_q + TIMEOUT_WIDTH'(1);
    if (rxValid || state_q == S_IDLE || expire)
      tmo_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_op_q   <= '0;
      sh_data_q <= '0;
      opcode_q  <= '0;
      cfg_q     <= '0;
      exec_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_op_q   <= sh_op_d;
      sh_data_q <= sh_data_d;
      opcode_q  <= opcode_d;
      cfg_q     <= cfg_d;
      exec_q    <= exec_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (rxValid && rxData[7]) state_d = S_DATA;
      S_DATA: begin
        if (rxValid && cnt_q == 2'd3) state_d = S_IDLE;
        else if (expire)              state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Visible opcode/config only change on completion; assembly stays in shadow.
  always_comb begin
    cnt_d     = cnt_q;
    sh_op_d   = sh_op_q;
    sh_data_d = sh_data_q;
    opcode_d  = opcode_q;
    cfg_d     = cfg_q;
    exec_d    = 1'b0;
    abort_d   = expire;
    unique case (1'b1)
      rxValid && state_q == S_IDLE && !rxData[7]: begin
        opcode_d = rxData;
        exec_d   = 1'b1;
      end
      rxValid && state_q == S_IDLE && rxData[7]: begin
        sh_op_d = rxData;
        cnt_d   = '0;
      end
      rxValid && state_q == S_DATA: begin
        sh_data_d[{cnt_q, 3'b000} +: 8] = rxData;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          opcode_d = sh_op_q;
          cfg_d    = {rxData, sh_data_q[23:0]};
          exec_d   = 1'b1;
        end
      end
      expire: begin
        sh_data_d = '0;
        cnt_d     = '0;
      end
      default: ;
    endcase
  end

  assign opcode      = opcode_q;
  assign config_data = cfg_q;
  assign execute     = exec_q;
  assign cmdAbort    = abort_q;
  assign parserIdle  = (state_q == S_IDLE);

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized bench for cmd_parser against a byte-queue command model.
// Timeout scenario expectations follow CMD_TIMEOUT_EN when defined.
module tb_cmd_parser;

  localparam int TCYC = 16;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute, parserIdle, cmdAbort;

  int vectors = 0;
  int miscompares = 0;

  cmd_parser #(.TIMEOUT_CYCLES(TCYC), .TIMEOUT_WIDTH(17)) dut (
    .clock(clock), .resetn(resetn), .rxData(rxData), .rxValid(rxValid),
    .opcode(opcode), .config_data(config_data), .execute(execute),
    .parserIdle(parserIdle), .cmdAbort(cmdAbort)
  );

  always #5 clock = ~clock;

  // Model: pending bytes of the command being collected, idle-gap length.
  logic [7:0]  pend[$];
  int          gap = 0;
  logic        m_exec = 0, m_abort = 0, m_idle = 1;
  logic [7:0]  m_op = 0;
  logic [31:0] m_cfg = 0;

  function automatic void model_step(input logic r, input logic v,
                                     input logic [7:0] d);
    m_exec  = 0;
    m_abort = 0;
    if (!r) begin
      pend.delete();
      gap = 0; m_op = 0; m_cfg = 0;
    end else if (v) begin
      gap = 0;
      pend.push_back(d);
      if (!pend[0][7]) begin
        m_op = pend[0]; m_exec = 1; pend.delete();
      end else if (pend.size() == 5) begin
        m_op   = pend[0];
        m_cfg  = {pend[4], pend[3], pend[2], pend[1]};
        m_exec = 1;
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      gap++;
`ifdef CMD_TIMEOUT_EN
      if (gap == TCYC) begin
        m_abort = 1; pend.delete(); gap = 0;
      end
`endif
    end
    m_idle = (pend.size() == 0);
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    resetn = r; rxValid = v; rxData = d;
    @(posedge clock);
    #1;
    model_step(r, v, d);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom), 8'($urandom));
      vectors++;
      if ({execute, parserIdle, cmdAbort, opcode, config_data} !==
          {1'b0, 1'b1, 1'b0, 8'h00, 32'h0}) begin
        miscompares++;
        $display("FAIL reset: ex=%b idle=%b ab=%b op=%h cfg=%h want 0 1 0 00 0",
                 execute, parserIdle, cmdAbort, opcode, config_data);
      end
    end
  endtask

  task automatic test_short();
    drive(1'b1, 1'b1, 8'h01);
    vectors++;
    if ({execute, opcode, config_data} !== {1'b1, 8'h01, 32'h0}) begin
      miscompares++;
      $display("FAIL short: ex=%b op=%h cfg=%h want 1 01 0",
               execute, opcode, config_data);
    end
    drive(1'b1, 1'b0, 8'h00);
    vectors++;
    if ({execute, opcode} !== {1'b0, 8'h01}) begin
      miscompares++;
      $display("FAIL short_hold: ex=%b op=%h want 0 01", execute, opcode);
    end
  endtask

  task automatic test_long();
    logic [7:0] b[5];
    b = '{8'hC0, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, b[i]);
      vectors++;
      if ({execute, parserIdle, cmdAbort, opcode, config_data} !==
          {m_exec, m_idle, m_abort, m_op, m_cfg}) begin
        miscompares++;
        $display("FAIL long[%0d]: ex=%b idle=%b op=%h cfg=%h want %b %b %h %h",
                 i, execute, parserIdle, opcode, config_data,
                 m_exec, m_idle, m_op, m_cfg);
      end
    end
    vectors++;
    if ({opcode, config_data} !== {8'hC0, 32'h11223344}) begin
      miscompares++;
      $display("FAIL long_word: op=%h cfg=%h want C0 11223344",
               opcode, config_data);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b[3];
    int ex_cnt = 0;
    b = '{8'h81, 8'hAA, 8'hBB};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, b[i]);
      ex_cnt += int'(execute);
    end
    drive(1'b0, 1'b0, 8'h00);
    ex_cnt += int'(execute);
    drive(1'b1, 1'b1, 8'h02);
    vectors++;
    if ({ex_cnt, execute, opcode, config_data} !==
        {32'd0, 1'b1, 8'h02, m_cfg}) begin
      miscompares++;
      $display("FAIL reset_abort: early_ex=%0d ex=%b op=%h cfg=%h want 0 1 02 %h",
               ex_cnt, execute, opcode, config_data, m_cfg);
    end
  endtask

  task automatic test_sump_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'h00);
      vectors++;
      if ({execute, parserIdle, opcode} !== {1'b1, 1'b1, 8'h00}) begin
        miscompares++;
        $display("FAIL sump_reset[%0d]: ex=%b idle=%b op=%h want 1 1 00",
                 i, execute, parserIdle, opcode);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 4) d[7] = 1'b0;
      drive(1'b1, ($urandom_range(0, 9) < 8), d);
      vectors++;
      if ({execute, parserIdle, cmdAbort, opcode, config_data} !==
          {m_exec, m_idle, m_abort, m_op, m_cfg}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: ex=%b idle=%b ab=%b op=%h cfg=%h want %b %b %b %h %h",
                 i, execute, parserIdle, cmdAbort, opcode, config_data,
                 m_exec, m_idle, m_abort, m_op, m_cfg);
      end
    end
  endtask

  task automatic test_gaps();
    while (!m_idle) drive(1'b1, 1'b1, 8'h00);
    for (int r = 0; r < 20; r++) begin
      logic [7:0] b[5];
      int ex_cnt = 0;
      b[0] = 8'hC1;
      for (int k = 1; k < 5; k++) b[k] = 8'($urandom);
      for (int k = 0; k < 5; k++) begin
        int g;
        g = $urandom_range(0, 7);
        for (int j = 0; j < g; j++) begin
          drive(1'b1, 1'b0, 8'($urandom));
          ex_cnt += int'(execute);
        end
        drive(1'b1, 1'b1, b[k]);
        ex_cnt += int'(execute);
      end
      vectors++;
      if ({ex_cnt, execute, opcode, config_data} !==
          {32'd1, 1'b1, 8'hC1, b[4], b[3], b[2], b[1]}) begin
        miscompares++;
        $display("FAIL gaps[%0d]: ex_cnt=%0d ex=%b op=%h cfg=%h want 1 1 C1 %h%h%h%h",
                 r, ex_cnt, execute, opcode, config_data, b[4], b[3], b[2], b[1]);
      end
    end
  endtask

  task automatic test_timeout();
    for (int gl = TCYC; gl >= TCYC - 1; gl--) begin
      int ab_cnt = 0, ex_cnt = 0;
      logic exp_ab;
      drive(1'b1, 1'b1, 8'h82);
      drive(1'b1, 1'b1, 8'h01);
      for (int j = 0; j < gl; j++) begin
        drive(1'b1, 1'b0, 8'h00);
        ab_cnt += int'(cmdAbort);
        ex_cnt += int'(execute);
        vectors++;
        if ({cmdAbort, parserIdle} !== {m_abort, m_idle}) begin
          miscompares++;
          $display("FAIL timeout_gap%0d[%0d]: ab=%b idle=%b want %b %b",
                   gl, j, cmdAbort, parserIdle, m_abort, m_idle);
        end
      end
`ifdef CMD_TIMEOUT_EN
      exp_ab = (gl == TCYC);
`else
      exp_ab = 1'b0;
`endif
      vectors++;
      if ({ab_cnt, ex_cnt} !== {31'd0, exp_ab, 32'd0}) begin
        miscompares++;
        $display("FAIL timeout_count%0d: aborts=%0d execs=%0d want %0d 0",
                 gl, ab_cnt, ex_cnt, exp_ab);
      end
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 8'(8'h10 + k));
      drive(1'b1, 1'b1, 8'h01);
      vectors++;
      if ({execute, opcode, config_data} !== {m_exec, m_op, m_cfg}) begin
        miscompares++;
        $display("FAIL timeout_after%0d: ex=%b op=%h cfg=%h want %b %h %h",
                 gl, execute, opcode, config_data, m_exec, m_op, m_cfg);
      end
      while (!m_idle) drive(1'b1, 1'b1, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_reset_abort();
    test_sump_reset();
    test_back_to_back();
    test_gaps();
    test_timeout();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
